// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix-multiply sequencer.
package matmul_pkg;

   localparam int SIZE_DEF     = 16;
   localparam int TO_SLACK_DEF = 8;
   localparam int IDX_W        = $clog2(SIZE_DEF);
   localparam int DIM_W        = IDX_W + 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE  = 3'd1,
      WAIT   = 3'd2,
      WRITE  = 3'd3,
      NEXT   = 3'd4,
      FINISH = 3'd5
   } state_e;

   // A matrix dimension is usable when it is non-zero and fits the array.
   function automatic logic dim_valid(input logic [31:0] dim, input logic [31:0] max_dim);
      return (dim != 32'd0) && (dim <= max_dim);
   endfunction

endpackage

// File: rtl/matmul_idx_counter.sv
// Row/column walker for the output matrix: row-major order, column wraps
// into the next row, and flags the final element of the job.
module matmul_idx_counter #(
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             advance,
   input  logic [IDX_W:0]   rows,
   input  logic [IDX_W:0]   cols,
   output logic [IDX_W-1:0] row_idx,
   output logic [IDX_W-1:0] col_idx,
   output logic             last
);

   localparam int DIM_W = IDX_W + 1;
   localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [DIM_W-1:0] DIM_ONE  = DIM_W'(1);

   logic [IDX_W-1:0] row_q, row_d;
   logic [IDX_W-1:0] col_q, col_d;
   logic             col_wrap_s;

   assign col_wrap_s = ({1'b0, col_q} == (cols - DIM_ONE));
   assign last       = col_wrap_s && ({1'b0, row_q} == (rows - DIM_ONE));
   assign row_idx    = row_q;
   assign col_idx    = col_q;

   // Next index: clear wins, otherwise step one element in row-major order.
   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (clear) begin
         row_d = IDX_ZERO;
         col_d = IDX_ZERO;
      end else if (advance) begin
         if (col_wrap_s) begin
            col_d = IDX_ZERO;
            row_d = row_q + IDX_ONE;
         end else begin
            col_d = col_q + IDX_ONE;
         end
      end else begin
         row_d = row_q;
         col_d = col_q;
      end
   end

   // Index registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         row_q <= IDX_ZERO;
         col_q <= IDX_ZERO;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

endmodule

// File: rtl/matmul_scheduler.sv
// Sequencer for C = A * B: one dot-product job per output element on the
// MAC control unit, with a watchdog on each job and a valid/ready writeback.
module matmul_scheduler
   import matmul_pkg::*;
#(
   parameter int SIZE     = SIZE_DEF,
   parameter int TO_SLACK = TO_SLACK_DEF
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic                      abort,
   input  logic [$clog2(SIZE):0]     cfg_rows,
   input  logic [$clog2(SIZE):0]     cfg_cols,
   input  logic [$clog2(SIZE):0]     cfg_inner,
   output logic                      dp_start,
   output logic [$clog2(SIZE):0]     dp_cycles,
   output logic                      dp_reset,
   input  logic                      dp_done,
   output logic [$clog2(SIZE)-1:0]   row_idx,
   output logic [$clog2(SIZE)-1:0]   col_idx,
   output logic                      wb_valid,
   input  logic                      wb_ready,
   output logic                      busy,
   output logic                      done,
   output logic                      err
);

   localparam int IW   = $clog2(SIZE);
   localparam int DW   = IW + 1;
   localparam int TO_W = $clog2(3 * SIZE + TO_SLACK + 1);
   localparam logic [TO_W-1:0] TO_ZERO = {TO_W{1'b0}};
   localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
   localparam logic [DW-1:0]   DIM_ZERO = {DW{1'b0}};

   state_e          state_q, state_d;
   logic [DW-1:0]   rows_q, rows_d;
   logic [DW-1:0]   cols_q, cols_d;
   logic [DW-1:0]   inner_q, inner_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            err_flag_q, err_flag_d;
   logic            dp_start_q, dp_start_d;
   logic            dp_reset_q, dp_reset_d;
   logic            wb_valid_q, wb_valid_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            err_q, err_d;

   logic            cfg_ok_s;
   logic [TO_W-1:0] to_limit_s;
   logic [TO_W-1:0] to_cnt_inc_s;
   logic            idx_clear_s;
   logic            idx_advance_s;
   logic            idx_last_s;

   assign cfg_ok_s = dim_valid(32'(cfg_rows), 32'(SIZE)) &&
                     dim_valid(32'(cfg_cols), 32'(SIZE)) &&
                     dim_valid(32'(cfg_inner), 32'(SIZE));

   // A job normally takes about three cycles per MAC step; beyond that plus slack it is hung.
   assign to_limit_s   = TO_W'(inner_q) * TO_W'(3) + TO_W'(TO_SLACK);
   assign to_cnt_inc_s = to_cnt_q + TO_ONE;

   matmul_idx_counter #(
      .IDX_W (IW)
   ) u_idx (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (idx_clear_s),
      .advance (idx_advance_s),
      .rows    (rows_q),
      .cols    (cols_q),
      .row_idx (row_idx),
      .col_idx (col_idx),
      .last    (idx_last_s)
   );

   // Next-state and next-output logic; every output is launched one edge early so it is a flop.
   always_comb begin
      state_d       = state_q;
      rows_d        = rows_q;
      cols_d        = cols_q;
      inner_d       = inner_q;
      to_cnt_d      = to_cnt_q;
      err_flag_d    = err_flag_q;
      dp_start_d    = 1'b0;
      dp_reset_d    = 1'b0;
      wb_valid_d    = 1'b0;
      done_d        = 1'b0;
      err_d         = 1'b0;
      idx_clear_s   = 1'b0;
      idx_advance_s = 1'b0;

      if (abort && (state_q != IDLE)) begin
         // Abort overrides everything: kill the MAC job, drop writeback, no completion pulse.
         dp_reset_d = 1'b1;
         err_flag_d = 1'b0;
         state_d    = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  rows_d      = cfg_rows;
                  cols_d      = cfg_cols;
                  inner_d     = cfg_inner;
                  idx_clear_s = 1'b1;
                  if (cfg_ok_s) begin
                     dp_start_d = 1'b1;
                     state_d    = ISSUE;
                  end else begin
                     err_flag_d = 1'b1;
                     state_d    = FINISH;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
            ISSUE: begin
               to_cnt_d = TO_ZERO;
               state_d  = WAIT;
            end
            WAIT: begin
               to_cnt_d = to_cnt_inc_s;
               if (dp_done) begin
                  // A done that lands on the timeout cycle still counts as success.
                  wb_valid_d = 1'b1;
                  state_d    = WRITE;
               end else if (to_cnt_inc_s == to_limit_s) begin
                  dp_reset_d = 1'b1;
                  err_flag_d = 1'b1;
                  state_d    = FINISH;
               end else begin
                  state_d = WAIT;
               end
            end
            WRITE: begin
               // WRITE and NEXT also give the MAC unit its two recovery cycles before the next start.
               if (wb_ready) begin
                  state_d = NEXT;
               end else begin
                  wb_valid_d = 1'b1;
               end
            end
            NEXT: begin
               idx_advance_s = 1'b1;
               if (idx_last_s) begin
                  done_d  = 1'b1;
                  state_d = FINISH;
               end else begin
                  dp_start_d = 1'b1;
                  state_d    = ISSUE;
               end
            end
            FINISH: begin
               // Success already raised done on the way in; error exits raise done+err here.
               done_d     = err_flag_q;
               err_d      = err_flag_q;
               err_flag_d = 1'b0;
               state_d    = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   // State, latched configuration and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         rows_q     <= DIM_ZERO;
         cols_q     <= DIM_ZERO;
         inner_q    <= DIM_ZERO;
         to_cnt_q   <= TO_ZERO;
         err_flag_q <= 1'b0;
         dp_start_q <= 1'b0;
         dp_reset_q <= 1'b0;
         wb_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rows_q     <= rows_d;
         cols_q     <= cols_d;
         inner_q    <= inner_d;
         to_cnt_q   <= to_cnt_d;
         err_flag_q <= err_flag_d;
         dp_start_q <= dp_start_d;
         dp_reset_q <= dp_reset_d;
         wb_valid_q <= wb_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign dp_start  = dp_start_q;
   assign dp_cycles = inner_q;
   assign dp_reset  = dp_reset_q;
   assign wb_valid  = wb_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_matmul_scheduler.sv
// Directed bench for matmul_scheduler with a behavioural MAC unit model.
module tb_matmul_scheduler;

   localparam int MAC_D = 11;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic       abort;
   logic [4:0] cfg_rows;
   logic [4:0] cfg_cols;
   logic [4:0] cfg_inner;
   logic       dp_start;
   logic [4:0] dp_cycles;
   logic       dp_reset;
   logic       dp_done;
   logic [3:0] row_idx;
   logic [3:0] col_idx;
   logic       wb_valid;
   logic       wb_ready;
   logic       busy;
   logic       done;
   logic       err;

   int n_checks = 0;
   int n_fail   = 0;

   // Monitor / MAC model state
   int         cyc_cnt       = 0;
   int         mac_cnt       = 0;
   bit         mac_en        = 1'b1;
   int         last_done_cyc = 0;
   int         min_gap       = 1000;
   int         n_dps         = 0;
   int         n_done        = 0;
   logic [7:0] idx_log[$];

   matmul_scheduler dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .abort     (abort),
      .cfg_rows  (cfg_rows),
      .cfg_cols  (cfg_cols),
      .cfg_inner (cfg_inner),
      .dp_start  (dp_start),
      .dp_cycles (dp_cycles),
      .dp_reset  (dp_reset),
      .dp_done   (dp_done),
      .row_idx   (row_idx),
      .col_idx   (col_idx),
      .wb_valid  (wb_valid),
      .wb_ready  (wb_ready),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // MAC unit model (done MAC_D cycles after start) plus pulse monitor.
   always @(negedge clk) begin
      cyc_cnt = cyc_cnt + 1;
      dp_done = 1'b0;
      if (mac_cnt != 0) begin
         mac_cnt = mac_cnt - 1;
         if (mac_cnt == 0) dp_done = 1'b1;
      end
      if (dp_reset === 1'b1) mac_cnt = 0;
      else if (dp_start === 1'b1 && mac_en) mac_cnt = MAC_D;
      if (dp_done) last_done_cyc = cyc_cnt;
      if (dp_start === 1'b1) begin
         n_dps = n_dps + 1;
         idx_log.push_back({row_idx, col_idx});
         if (last_done_cyc > 0 && (cyc_cnt - last_done_cyc) < min_gap)
            min_gap = cyc_cnt - last_done_cyc;
      end
      if (done === 1'b1) n_done = n_done + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [4:0] r, input logic [4:0] c, input logic [4:0] i);
      cfg_rows  = r;
      cfg_cols  = c;
      cfg_inner = i;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   initial begin
      int         cyc;
      int         n0;
      int         d0;
      int         i0;
      logic [7:0] exp_idx [4];
      logic [7:0] got;

      exp_idx[0] = 8'h00;
      exp_idx[1] = 8'h01;
      exp_idx[2] = 8'h10;
      exp_idx[3] = 8'h11;

      reset_n   = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      cfg_rows  = 5'd0;
      cfg_cols  = 5'd0;
      cfg_inner = 5'd0;
      wb_ready  = 1'b1;
      dp_done   = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_dp_start", dp_start, 0);
      chk("rst_dp_reset", dp_reset, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_dp_cycles", dp_cycles, 0);
      chk("rst_idx", {row_idx, col_idx}, 0);
      reset_n = 1'b1;
      tick();

      // 2x2, inner=3, D=11: 4 jobs of 14 cycles, done at cycle 57
      n0 = n_dps; d0 = n_done; i0 = idx_log.size();
      pulse_start(5'd2, 5'd2, 5'd3);
      cyc = 1;
      chk("t1_dp_start", dp_start, 1);
      chk("t1_busy", busy, 1);
      chk("t1_dp_cycles", dp_cycles, 3);
      while (done !== 1'b1 && cyc < 200) begin tick(); cyc++; end
      chk("t1_done_cycle", cyc, 57);
      chk("t1_err", err, 0);
      tick(); tick();
      chk("t1_busy_after", busy, 0);
      chk("t1_done_count", n_done - d0, 1);
      chk("t1_dp_starts", n_dps - n0, 4);
      for (int k = 0; k < 4; k++) begin
         got = (i0 + k < idx_log.size()) ? idx_log[i0 + k] : 8'hFF;
         chk("t1_idx_order", got, exp_idx[k]);
      end
      chk("t1_done_to_start_gap", min_gap, 3);

      // Config error: cols=0, and rows above SIZE
      n0 = n_dps;
      pulse_start(5'd2, 5'd0, 5'd3);
      chk("t2_c1_done", done, 0);
      chk("t2_c1_busy", busy, 1);
      tick();
      chk("t2_c2_done_err", {done, err}, 2'b11);
      chk("t2_c2_busy", busy, 0);
      tick();
      chk("t2_c3_done", done, 0);
      pulse_start(5'd17, 5'd1, 5'd1);
      tick();
      chk("t2b_done_err", {done, err}, 2'b11);
      chk("t2_no_dp_start", n_dps - n0, 0);
      tick();

      // 1x1, writer stalls 5 cycles
      wb_ready = 1'b0;
      pulse_start(5'd1, 5'd1, 5'd2);
      cyc = 1;
      while (wb_valid !== 1'b1 && cyc < 100) begin tick(); cyc++; end
      chk("t3_wb_valid_cycle", cyc, 13);
      for (int k = 0; k < 6; k++) begin
         chk("t3_hold", {wb_valid, row_idx, col_idx}, 9'h100);
         if (k == 5) wb_ready = 1'b1;
         tick();
      end
      chk("t3_wb_valid_drop", wb_valid, 0);
      chk("t3_no_early_done", done, 0);
      tick();
      chk("t3_done_err", {done, err}, 2'b10);
      tick();

      // 1x1, inner=4, MAC never answers: 20 WAIT cycles then dp_reset, then done+err
      mac_en = 1'b0;
      pulse_start(5'd1, 5'd1, 5'd4);
      chk("t4_dp_start", dp_start, 1);
      repeat (20) tick();
      chk("t4_no_early_reset", dp_reset, 0);
      tick();
      chk("t4_dp_reset", dp_reset, 1);
      chk("t4_no_done_yet", done, 0);
      tick();
      chk("t4_done_err", {done, err}, 2'b11);
      chk("t4_reset_one_cycle", dp_reset, 0);
      tick();
      chk("t4_done_pulse", done, 0);
      mac_en = 1'b1;

      // 3x3, abort in WAIT of element (1,2), then a clean 1x1 (done and timeout coincide)
      n0 = n_dps; d0 = n_done;
      pulse_start(5'd3, 5'd3, 5'd2);
      cyc = 1;
      while (!(dp_start === 1'b1 && row_idx == 4'd1 && col_idx == 4'd2) && cyc < 300) begin
         tick(); cyc++;
      end
      chk("t5_elem12_cycle", cyc, 71);
      repeat (3) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t5_dp_reset", dp_reset, 1);
      chk("t5_busy", busy, 0);
      chk("t5_no_done", {done, err}, 2'b00);
      tick();
      chk("t5_reset_one_cycle", dp_reset, 0);
      repeat (20) tick();
      chk("t5_done_count", n_done - d0, 0);
      chk("t5_dp_starts", n_dps - n0, 6);
      pulse_start(5'd1, 5'd1, 5'd1);
      cyc = 1;
      while (done !== 1'b1 && cyc < 100) begin tick(); cyc++; end
      chk("t5b_done_cycle", cyc, 15);
      chk("t5b_err", err, 0);
      chk("t5b_dp_cycles", dp_cycles, 1);
      tick();

      // Start while busy is ignored
      n0 = n_dps; d0 = n_done;
      pulse_start(5'd2, 5'd2, 5'd3);
      cyc = 1;
      repeat (4) tick();
      cyc = 5;
      pulse_start(5'd3, 5'd3, 5'd5);
      cyc = 6;
      chk("t6_dp_cycles_kept", dp_cycles, 3);
      while (done !== 1'b1 && cyc < 200) begin tick(); cyc++; end
      chk("t6_done_cycle", cyc, 57);
      chk("t6_err", err, 0);
      tick(); tick();
      chk("t6_dp_starts", n_dps - n0, 4);
      chk("t6_done_count", n_done - d0, 1);
      chk("t6_dp_cycles_end", dp_cycles, 3);
      chk("all_done_to_start_gap", min_gap, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
